pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Upstream control stage for the VFO sample input: issues the periodic Sample strobe to the VFO.
//  Watches the comparator's AdjustFreq code at each strobe and declares or drops lock.
//  Sits beside the PLL top level, clocked by the PLL output clock.
//  Provides Locked / LockLost status to downstream logic.
// PARAMETERS
//  SAMPLE_PERIOD  16  clocks between Sample strobes (>=2)
//  LOCK_COUNT     4   consecutive in-lock evaluations needed to assert Locked (>=1)
//  UNLOCK_COUNT   2   consecutive bad evaluations needed to drop Locked (>=1)
// PORTS
//  Clock       in   1  PLL output clock; all logic on rising edge
//  Reset       in   1  synchronous, active-high reset
//  AdjustFreq  in   2  comparator code: 00 hold, 01 speed up, 10 slow down, 11 invalid
//  Sample      out  1  one-cycle strobe to VFO SampleCmd
//  Locked      out  1  lock status, registered
//  LockLost    out  1  one-cycle pulse when Locked falls
// BEHAVIOUR
//  Reset state: Sample=0, Locked=0, LockLost=0; all counters 0; state=ACQUIRE.
//  Reset overrides everything, including mid-acquire and mid-slip.
//  Period counter:
//   - runs 0..SAMPLE_PERIOD-1 and wraps.
//   - Sample is registered and high exactly when the counter = SAMPLE_PERIOD-1.
//   - First strobe is in cycle SAMPLE_PERIOD after Reset falls (cycle 1 = first edge with Reset=0).
//  Evaluation: AdjustFreq is sampled on the edge that ends each Sample-high cycle; no evaluation at other times.
//  good = (AdjustFreq==00); bad = 01 or 10; invalid = 11.
//  FSM (2-bit encoding: ACQUIRE=00, LOCKED=01, SLIPPING=10):
//   ACQUIRE:
//    - good: GoodCnt+1; when GoodCnt reaches LOCK_COUNT -> LOCKED, Locked=1 on that edge.
//    - bad/invalid: GoodCnt=0.
//   LOCKED:
//    - good: stay.
//    - bad: BadCnt=1; if UNLOCK_COUNT==1 -> ACQUIRE, else -> SLIPPING.
//    - invalid: -> ACQUIRE.
//   SLIPPING (Locked stays 1):
//    - good: -> LOCKED, BadCnt=0.
//    - bad: BadCnt+1; at UNLOCK_COUNT -> ACQUIRE.
//    - invalid: -> ACQUIRE.
//  Any transition LOCKED/SLIPPING -> ACQUIRE:
//   - Locked=0 and LockLost=1 on the same edge; LockLost clears next cycle.
//   - GoodCnt=0 and BadCnt=0.
//  Counter widths: $clog2(param+1); GoodCnt and BadCnt never exceed their thresholds.
//  The period counter is free-running and unaffected by FSM state; the Sample cadence never stalls.
// CONFIGURATION
//  PLL_SLIP_COUNT_EN defined:
//   - adds output SlipCount [7:0]: count of LockLost pulses.
//   - saturates at 255; reset to 0 only by Reset.
//  PLL_SLIP_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (defaults 16/4/2)
//  1 Reset release, AdjustFreq=00 constant -> Sample high in cycles 16,32,48,64 only; Locked rises at edge ending cycle 64; LockLost stays 0.
//  2 Evals 00,00,00,01,00,00,00,00 -> GoodCnt clears at 4th eval; Locked rises only at 8th eval (cycle 128).
//  3 Locked, evals 10,00,10,00 -> Locked stays 1 throughout; no LockLost pulse.
//  4 Locked, evals 01,10 -> Locked falls at 2nd eval; LockLost high exactly 1 cycle; relock needs 4 more 00 evals.
//  5 Locked, single eval 11 -> immediate unlock with LockLost pulse.
//    Reset pulsed at GoodCnt=3 -> Sample/Locked 0; next Sample 16 cycles after release.
//  6 PLL_SLIP_COUNT_EN: 300 forced unlocks -> SlipCount=255 (saturated).
//    Reset -> SlipCount=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: periodic Sample strobe to the VFO, lock/unlock tracking.
// Optional PLL_SLIP_COUNT_EN adds an 8-bit saturating SlipCount output.
module pll_lock_sequencer #(
    parameter int SAMPLE_PERIOD = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] AdjustFreq,
    output logic       Sample,
    output logic       Locked,
    output logic       LockLost
`ifdef PLL_SLIP_COUNT_EN
    ,
    output logic [7:0] SlipCount
`endif
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    localparam logic [PW-1:0] PLAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [GW-1:0] GLAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BLAST = BW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ACQUIRE  = 2'b00,
        LOCKED   = 2'b01,
        SLIPPING = 2'b10
    } state_t;

    state_t        state;
    logic [PW-1:0] period;
    logic [PW-1:0] period_next;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic          good;
    logic          bad;
    logic          invalid;
    logic          drop;

    always_comb begin
        period_next = (period == PLAST) ? '0 : period + PW'(1);
        good        = (AdjustFreq == 2'b00);
        invalid     = (AdjustFreq == 2'b11);
        bad         = !good && !invalid;
        drop        = 1'b0;
        // Evaluation only happens on the edge that ends a Sample-high cycle
        if (Sample) begin
            unique case (state)
                LOCKED:   drop = invalid || (bad && UNLOCK_COUNT == 1);
                SLIPPING: drop = invalid || (bad && bad_cnt == BLAST);
                default:  drop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            period <= '0;
            Sample <= 1'b0;
        end else begin
            period <= period_next;
            Sample <= (period_next == PLAST);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ACQUIRE;
            Locked   <= 1'b0;
            LockLost <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            LockLost <= 1'b0;
            if (drop) begin
                state    <= ACQUIRE;
                Locked   <= 1'b0;
                LockLost <= 1'b1;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else if (Sample) begin
                unique case (state)
                    ACQUIRE: begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GLAST) begin
                            state    <= LOCKED;
                            Locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (bad) begin
                            state   <= SLIPPING;
                            bad_cnt <= BW'(1);
                        end
                    end
                    SLIPPING: begin
                        if (good) begin
                            state   <= LOCKED;
                            bad_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + BW'(1);
                        end
                    end
                    default: begin
                        state <= ACQUIRE;
                    end
                endcase
            end
        end
    end

`ifdef PLL_SLIP_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            SlipCount <= 8'd0;
        end else if (drop && SlipCount != 8'hFF) begin
            SlipCount <= SlipCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer at default parameters 16/4/2.
// Exercises the slip counter when PLL_SLIP_COUNT_EN is defined.
module tb_pll_lock_sequencer;

    logic       Clock;
    logic       Reset;
    logic [1:0] AdjustFreq;
    logic       Sample;
    logic       Locked;
    logic       LockLost;
`ifdef PLL_SLIP_COUNT_EN
    logic [7:0] SlipCount;
`endif

    int checks;
    int failures;
    int kcyc;

    pll_lock_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .AdjustFreq(AdjustFreq),
        .Sample    (Sample),
        .Locked    (Locked),
        .LockLost  (LockLost)
`ifdef PLL_SLIP_COUNT_EN
        ,
        .SlipCount (SlipCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, kcyc);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One clock after reset release; Sample must be high only in cycles 16,32,...
    task automatic step();
        tick();
        kcyc++;
        chk("sample", int'(Sample), int'(kcyc % 16 == 15));
    endtask

    // One full sample window ending at the evaluation edge
    task automatic eval(input logic [1:0] code, input bit exp_lock,
                        input bit exp_lost);
        bit prev;
        prev = Locked;
        AdjustFreq = code;
        step();
        chk("lost_clear", int'(LockLost), 0);
        for (int i = 1; i < 15; i++) step();
        chk("lock_hold", int'(Locked), int'(prev));
        step();
        chk("eval_lock", int'(Locked), int'(exp_lock));
        chk("eval_lost", int'(LockLost), int'(exp_lost));
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        chk("rst_sample", int'(Sample), 0);
        chk("rst_locked", int'(Locked), 0);
        chk("rst_lost", int'(LockLost), 0);
        Reset = 1'b0;
        kcyc = 0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        kcyc       = 0;
        Reset      = 1'b1;
        AdjustFreq = 2'b00;
        @(negedge Clock);
        do_reset(3);

        // 1: constant good -> lock at edge ending cycle 64
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b1, 1'b0);
        chk("t1_cycle", kcyc, 64);

        // 2: bad 4th eval clears progress; lock at 8th eval (cycle 128)
        do_reset(2);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b01, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b1, 1'b0);
        chk("t2_cycle", kcyc, 128);

        // 3: isolated bad evals never drop lock
        eval(2'b10, 1'b1, 1'b0);
        eval(2'b00, 1'b1, 1'b0);
        eval(2'b10, 1'b1, 1'b0);
        eval(2'b00, 1'b1, 1'b0);

        // 4: two bad evals drop lock; relock needs four good evals
        eval(2'b01, 1'b1, 1'b0);
        eval(2'b10, 1'b0, 1'b1);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b1, 1'b0);

        // 5: invalid code drops lock at once, also from SLIPPING
        eval(2'b11, 1'b0, 1'b1);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b1, 1'b0);
        eval(2'b01, 1'b1, 1'b0);
        eval(2'b11, 1'b0, 1'b1);

        // 5b: reset mid-window with GoodCnt=3 restarts cadence and count
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step();
        do_reset(2);
        eval(2'b00, 1'b0, 1'b0);
        chk("t5_cycle", kcyc, 16);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b0, 1'b0);
        eval(2'b00, 1'b1, 1'b0);

`ifdef PLL_SLIP_COUNT_EN
        // 6: slip counter saturates at 255 and clears only by reset
        do_reset(2);
        chk("slip_rst", int'(SlipCount), 0);
        for (int n = 1; n <= 300; n++) begin
            eval(2'b00, 1'b0, 1'b0);
            eval(2'b00, 1'b0, 1'b0);
            eval(2'b00, 1'b0, 1'b0);
            eval(2'b00, 1'b1, 1'b0);
            eval(2'b11, 1'b0, 1'b1);
            if (n == 10) chk("slip_10", int'(SlipCount), 10);
            if (n == 255) chk("slip_255", int'(SlipCount), 255);
        end
        chk("slip_sat", int'(SlipCount), 255);
        do_reset(2);
        chk("slip_clr", int'(SlipCount), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
